// File: rtl/rr_multiplexer_pkg.sv
// Shared types and helpers for the 4:1 stream mux and its 1:4 demux peer.
// Exports NUM_CH, SEL_W, DEF_W, state_e and the one-hot to index mapper.
package mux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int DEF_W  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // OR-reduction form: no priority chain, exact for one-hot inputs.
  function automatic logic [SEL_W-1:0] oh2idx(
    input logic [NUM_CH-1:0] oh
  );
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/rr_multiplexer_if.sv
// Handshake bundle of the 4:1 mux: four input channels, one output, enable.
// slave: the mux side; master: the environment driving inputs and Y_ready.
interface rr_multiplexer_if
  import mux_pkg::*;
#(
  parameter int W = DEF_W
);
  logic                E;
  logic [NUM_CH-1:0]   I_valid;
  logic [NUM_CH*W-1:0] I_data;
  logic [NUM_CH-1:0]   I_ready;
  logic                Y_valid;
  logic [W-1:0]        Y_data;
  logic [SEL_W-1:0]    S;
  logic                Y_ready;

  modport slave (
    input  E, I_valid, I_data, Y_ready,
    output I_ready, Y_valid, Y_data, S
  );

  modport master (
    output E, I_valid, I_data, Y_ready,
    input  I_ready, Y_valid, Y_data, S
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Combinational round-robin arbiter: rotate, pick lowest, rotate back.
// req/ptr/en in; one-hot grant and its index gidx out.
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       en,
  output logic [3:0] grant,
  output logic [1:0] gidx
);
  logic [7:0] dbl;
  logic [3:0] rot;
  logic [3:0] pick;
  logic [7:0] back;

  always_comb begin
    // rot[j] is channel (ptr+j) mod 4, so bit 0 has top priority
    dbl  = {req, req} >> ptr;
    rot  = dbl[3:0];
    pick = rot & (~rot + 4'd1);
    back = {pick, pick} << ptr;
    grant = en ? back[7:4] : 4'b0000;
    gidx  = oh2idx(grant);
  end
endmodule

// File: rtl/rr_multiplexer.sv
// Registered round-robin 4:1 stream mux; each word tagged with source S.
// Ports: clk, rst (sync, active high), bus (slave modport of rr_multiplexer_if).
module rr_multiplexer
  import mux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic        clk,
  input  logic        rst,
  rr_multiplexer_if.slave bus
);
  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [W-1:0]     y_data_q, y_data_d;
  logic [SEL_W-1:0] s_q, s_d;

  logic       load_ok;
  logic       arb_en;
  logic [3:0] grant;
  logic [1:0] gidx;

  assign load_ok = (state_q == EMPTY) | bus.Y_ready;
  // rst gating keeps I_ready low during reset
  assign arb_en  = bus.E & load_ok & ~rst;

  rr_arbiter4 u_arb (
    .req   (bus.I_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant),
    .gidx  (gidx)
  );

  assign bus.I_ready = grant;
  assign bus.Y_valid = (state_q == FULL);
  assign bus.Y_data  = y_data_q;
  assign bus.S       = s_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    y_data_d = y_data_q;
    s_d      = s_q;
    if (|grant) begin
      state_d  = FULL;
      ptr_d    = gidx + 2'd1;
      y_data_d = bus.I_data[int'(gidx)*W +: W];
      s_d      = gidx;
    end else if ((state_q == FULL) && bus.Y_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      ptr_q    <= 2'd0;
      y_data_q <= '0;
      s_q      <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      y_data_q <= y_data_d;
      s_q      <= s_d;
    end
  end
endmodule

// File: tb/tb_rr_multiplexer.sv
// Directed vector bench for rr_multiplexer.
// Checks comb I_ready before each edge and registered outputs after it.
module tb_rr_multiplexer;
  import mux_pkg::*;

  logic clk;
  logic rst;

  rr_multiplexer_if #(.W(8)) bus ();

  rr_multiplexer #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        e;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        yr;
    logic [3:0]  x_ready;
    logic        x_yv;
    logic [7:0]  x_yd;
    logic [1:0]  x_s;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  int checks;
  int failures;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst         = v.rst;
    bus.E       = v.e;
    bus.I_valid = v.valid;
    bus.I_data  = v.data;
    bus.Y_ready = v.yr;
    #1;
    chk("I_ready", idx, 32'(bus.I_ready), 32'(v.x_ready));
    @(posedge clk);
    #1;
    chk("Y_valid", idx, 32'(bus.Y_valid), 32'(v.x_yv));
    chk("Y_data", idx, 32'(bus.Y_data), 32'(v.x_yd));
    chk("S", idx, 32'(bus.S), 32'(v.x_s));
  endtask

  localparam logic [31:0] D0 = 32'h44332211;
  localparam logic [31:0] D1 = 32'h44A52211;
  localparam logic [31:0] D2 = 32'h44A53C11;

  initial begin
    checks   = 0;
    failures = 0;
    rst         = 1'b1;
    bus.E       = 1'b1;
    bus.I_valid = 4'b0000;
    bus.I_data  = '0;
    bus.Y_ready = 1'b1;

    // rotation 0,1,2,3,0 from reset
    vecs[0]  = '{1, 1, 4'b1111, D0, 1, 4'b0000, 0, 8'h00, 2'd0};
    vecs[1]  = '{0, 1, 4'b1111, D0, 1, 4'b0001, 1, 8'h11, 2'd0};
    vecs[2]  = '{0, 1, 4'b1111, D0, 1, 4'b0010, 1, 8'h22, 2'd1};
    vecs[3]  = '{0, 1, 4'b1111, D0, 1, 4'b0100, 1, 8'h33, 2'd2};
    vecs[4]  = '{0, 1, 4'b1111, D0, 1, 4'b1000, 1, 8'h44, 2'd3};
    vecs[5]  = '{0, 1, 4'b1111, D0, 1, 4'b0001, 1, 8'h11, 2'd0};
    // single request ch2, then ptr=3 picks ch3
    vecs[6]  = '{1, 1, 4'b0100, D1, 1, 4'b0000, 0, 8'h00, 2'd0};
    vecs[7]  = '{0, 1, 4'b0100, D1, 1, 4'b0100, 1, 8'hA5, 2'd2};
    vecs[8]  = '{0, 1, 4'b1111, D1, 1, 4'b1000, 1, 8'h44, 2'd3};
    // backpressure hold of ch1, then ch3 next
    vecs[9]  = '{0, 1, 4'b0010, D2, 1, 4'b0010, 1, 8'h3C, 2'd1};
    vecs[10] = '{0, 1, 4'b1010, D2, 0, 4'b0000, 1, 8'h3C, 2'd1};
    vecs[11] = '{0, 1, 4'b1010, D2, 0, 4'b0000, 1, 8'h3C, 2'd1};
    vecs[12] = '{0, 1, 4'b1010, D2, 0, 4'b0000, 1, 8'h3C, 2'd1};
    vecs[13] = '{0, 1, 4'b1010, D2, 1, 4'b1000, 1, 8'h44, 2'd3};
    // E low drains, ptr frozen at 2
    vecs[14] = '{0, 1, 4'b0010, D2, 1, 4'b0010, 1, 8'h3C, 2'd1};
    vecs[15] = '{0, 0, 4'b1111, D2, 1, 4'b0000, 0, 8'h3C, 2'd1};
    vecs[16] = '{0, 0, 4'b1111, D2, 1, 4'b0000, 0, 8'h3C, 2'd1};
    vecs[17] = '{0, 1, 4'b1111, D2, 1, 4'b0100, 1, 8'hA5, 2'd2};
    // reset while FULL with ptr=2
    vecs[18] = '{0, 1, 4'b0010, D2, 1, 4'b0010, 1, 8'h3C, 2'd1};
    vecs[19] = '{1, 1, 4'b1111, D2, 1, 4'b0000, 0, 8'h00, 2'd0};
    vecs[20] = '{0, 1, 4'b1111, D2, 1, 4'b0001, 1, 8'h11, 2'd0};
    // idle, then load into EMPTY with Y_ready low
    vecs[21] = '{0, 1, 4'b0000, D2, 1, 4'b0000, 0, 8'h11, 2'd0};
    vecs[22] = '{0, 1, 4'b0100, D2, 0, 4'b0100, 1, 8'hA5, 2'd2};
    vecs[23] = '{0, 1, 4'b0001, D2, 0, 4'b0000, 1, 8'hA5, 2'd2};

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // wrap search: ptr=3 after the ch2 grant, lone ch1 request
    // must still be found within a bounded number of cycles
    begin
      int waited;
      bit seen;
      @(negedge clk);
      rst         = 1'b0;
      bus.Y_ready = 1'b1;
      bus.I_valid = 4'b0010;
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < 8) begin
        #1;
        if (bus.I_ready == 4'b0010) seen = 1'b1;
        else begin
          @(negedge clk);
          waited++;
        end
      end
      chk("wrap_grant_seen", 100, 32'(seen), 32'd1);
      chk("wrap_wait", 100, 32'(waited), 32'd0);
      @(posedge clk);
      #1;
      chk("wrap_S", 100, 32'(bus.S), 32'd1);
      chk("wrap_Y_data", 100, 32'(bus.Y_data), 32'h3C);
      @(negedge clk);
      bus.I_valid = 4'b0000;
      @(posedge clk);
      #1;
      chk("wrap_drain", 100, 32'(bus.Y_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
